// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite request scheduler: response codes,
// scheduler FSM states and the grant-index width helper.
package axi_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [2:0] {
      IDLE,
      WR_AW_W,
      WR_B,
      RD_AR,
      RD_R,
      RESP
   } sched_state_t;

   // A single requester still needs a one-bit index signal.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Round-robin grant search: first set request at or above ptr_i, with wrap.
// Purely combinational; the pointer register is owned by the caller.
module axi_rr_arbiter
   import axi_lite_pkg::*;
#(
   parameter int N    = 2,
   parameter int IdxW = idx_width(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] idx_o,
   output logic            vld_o
);

   int cand;

   // Walk the requesters starting at ptr_i and keep only the first hit.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      cand  = 0;
      for (int i = 0; i < N; i++) begin
         cand = (int'(ptr_i) + i) % N;
         if (!vld_o && req_i[cand[IdxW-1:0]]) begin
            vld_o = 1'b1;
            gnt_o = N'(1) << cand;
            idx_o = cand[IdxW-1:0];
         end
      end
   end

endmodule

// File: rtl/axi_lite_req_scheduler.sv
// Shares one AXI4-Lite slave between N held-request ports. One complete
// transaction is in flight at a time; requesters are served round-robin and
// receive a one-cycle rsp_valid pulse. Every output comes from a register.
module axi_lite_req_scheduler
   import axi_lite_pkg::*;
#(
   parameter int N     = 2,
   parameter int Width = 32
) (
   input  logic                     ACLK,
   input  logic                     ARESETN,
   input  logic [N-1:0]             req,
   input  logic [N-1:0]             req_we,
   input  logic [N*Width-1:0]       req_addr,
   input  logic [N*Width-1:0]       req_wdata,
   input  logic [N*(Width/8)-1:0]   req_wstrb,
   output logic [N-1:0]             rsp_valid,
   output logic [Width-1:0]         rsp_rdata,
   output logic [1:0]               rsp_resp,
   output logic                     AWVALID,
   input  logic                     AWREADY,
   output logic [Width-1:0]         AWADDR,
   output logic                     WVALID,
   input  logic                     WREADY,
   output logic [Width-1:0]         WDATA,
   output logic [(Width/8)-1:0]     WSTRB,
   input  logic                     BVALID,
   output logic                     BREADY,
   input  logic [1:0]               BRESP,
   output logic                     ARVALID,
   input  logic                     ARREADY,
   output logic [Width-1:0]         ARADDR,
   input  logic                     RVALID,
   output logic                     RREADY,
   input  logic [Width-1:0]         RDATA,
   input  logic [1:0]               RRESP
);

   localparam int IdxW  = idx_width(N);
   localparam int StrbW = Width / 8;

   sched_state_t         state_q;
   logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]      idx_q;
   logic [N-1:0]         gnt_q;
   logic                 awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic [Width-1:0]     addr_q, wdata_q;
   logic [StrbW-1:0]     wstrb_q;
   logic [N-1:0]         rsp_valid_q;
   logic [Width-1:0]     rsp_rdata_q;
   resp_t                rsp_resp_q;

   logic [N-1:0]         arb_gnt;
   logic [IdxW-1:0]      arb_idx;
   logic                 arb_vld;

   axi_rr_arbiter #(
      .N    (N),
      .IdxW (IdxW)
   ) u_arb (
      .req_i (req),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .vld_o (arb_vld)
   );

   // The requester after the one just served gets first look next time.
   assign rr_ptr_d = (int'(idx_q) == N - 1) ? '0 : idx_q + 1'b1;

   // Transaction sequencer: grant, drive the AXI channels, report completion.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         idx_q       <= '0;
         gnt_q       <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= OKAY;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_vld) begin
                  idx_q   <= arb_idx;
                  gnt_q   <= arb_gnt;
                  addr_q  <= req_addr[int'(arb_idx)*Width +: Width];
                  wdata_q <= req_wdata[int'(arb_idx)*Width +: Width];
                  wstrb_q <= req_wstrb[int'(arb_idx)*StrbW +: StrbW];
                  if (|(req_we & arb_gnt)) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= WR_AW_W;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= RD_AR;
                  end
               end
            end
            WR_AW_W: begin
               // Address and data handshakes retire independently.
               if (AWREADY) awvalid_q <= 1'b0;
               if (WREADY)  wvalid_q  <= 1'b0;
               if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY)) begin
                  bready_q <= 1'b1;
                  state_q  <= WR_B;
               end
            end
            WR_B: begin
               if (BVALID) begin
                  bready_q    <= 1'b0;
                  rsp_resp_q  <= resp_t'(BRESP);
                  rsp_rdata_q <= '0;
                  rsp_valid_q <= gnt_q;
                  state_q     <= RESP;
               end
            end
            RD_AR: begin
               if (ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= RD_R;
               end
            end
            RD_R: begin
               if (RVALID) begin
                  rready_q    <= 1'b0;
                  rsp_rdata_q <= RDATA;
                  rsp_resp_q  <= resp_t'(RRESP);
                  rsp_valid_q <= gnt_q;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               rsp_valid_q <= '0;
               rr_ptr_q    <= rr_ptr_d;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign AWVALID   = awvalid_q;
   assign WVALID    = wvalid_q;
   assign BREADY    = bready_q;
   assign ARVALID   = arvalid_q;
   assign RREADY    = rready_q;
   assign AWADDR    = addr_q;
   assign ARADDR    = addr_q;
   assign WDATA     = wdata_q;
   assign WSTRB     = wstrb_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_req_scheduler.sv
// Bench for axi_lite_req_scheduler: directed cycle-exact steps followed by a
// randomized phase checked against a rotation-order / memory reference model.
module tb_axi_lite_req_scheduler;

   localparam int N  = 2;
   localparam int W  = 32;
   localparam int SW = W / 8;

   logic            ACLK = 1'b0;
   logic            ARESETN;
   logic [N-1:0]    req, req_we;
   logic [N*W-1:0]  req_addr, req_wdata;
   logic [N*SW-1:0] req_wstrb;
   logic [N-1:0]    rsp_valid;
   logic [W-1:0]    rsp_rdata;
   logic [1:0]      rsp_resp;
   logic            AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic            ARVALID, ARREADY, RVALID, RREADY;
   logic [W-1:0]    AWADDR, WDATA, ARADDR, RDATA;
   logic [SW-1:0]   WSTRB;
   logic [1:0]      BRESP, RRESP;

   int tests = 0;
   int fails = 0;

   // slave configuration and state
   int          cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
   logic [1:0]  cfg_resp;
   bit          rand_mode;
   int          aw_c, w_c, b_c, ar_c, r_c;
   int          aw_r, w_r, b_r, ar_r, r_r;
   logic [31:0] s_awaddr, s_wdata, s_araddr;
   logic [3:0]  s_wstrb;
   logic [31:0] slv_mem [16];

   // reference model state
   logic [31:0] model_mem [16];
   logic        op_we    [N];
   logic [31:0] op_addr  [N];
   logic [31:0] op_wdata [N];
   logic [3:0]  op_wstrb [N];
   int          overlap = 0;

   axi_lite_req_scheduler #(.N(N), .Width(W)) dut (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .req       (req),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_resp  (rsp_resp),
      .AWVALID   (AWVALID),
      .AWREADY   (AWREADY),
      .AWADDR    (AWADDR),
      .WVALID    (WVALID),
      .WREADY    (WREADY),
      .WDATA     (WDATA),
      .WSTRB     (WSTRB),
      .BVALID    (BVALID),
      .BREADY    (BREADY),
      .BRESP     (BRESP),
      .ARVALID   (ARVALID),
      .ARREADY   (ARREADY),
      .ARADDR    (ARADDR),
      .RVALID    (RVALID),
      .RREADY    (RREADY),
      .RDATA     (RDATA),
      .RRESP     (RRESP)
   );

   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] rsp_for(input logic [31:0] a);
      return rand_mode ? a[9:8] : cfg_resp;
   endfunction

   task automatic set_req(input int i, input logic we, input logic [31:0] a, d, input logic [3:0] s);
      req_we[i]            = we;
      req_addr[i*W +: W]   = a;
      req_wdata[i*W +: W]  = d;
      req_wstrb[i*SW +: SW] = s;
   endtask

   task automatic new_op(input int i);
      logic [31:0] a;
      a = {22'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
      op_we[i]    = 1'($urandom_range(0, 1));
      op_addr[i]  = a;
      op_wdata[i] = $urandom;
      op_wstrb[i] = 4'($urandom_range(0, 15));
      set_req(i, op_we[i], a, op_wdata[i], op_wstrb[i]);
   endtask

   task automatic wait_rsp(input string tag, output logic [N-1:0] who);
      int c;
      c = 0;
      while (rsp_valid == '0 && c < 200) begin
         @(negedge ACLK);
         c++;
      end
      check({tag, "_done"}, 64'(rsp_valid != '0), 64'd1);
      who = rsp_valid;
   endtask

   // AXI4-Lite slave: configurable READY/VALID wait cycles, word memory.
   initial begin
      AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
      ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
      aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
      aw_r = 0; w_r = 0; b_r = 0; ar_r = 0; r_r = 0;
      s_awaddr = 0; s_wdata = 0; s_wstrb = 0; s_araddr = 0;
      forever begin
         @(negedge ACLK);
         if (!ARESETN) begin
            AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
            aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
         end else begin
            if (AWVALID) begin
               if (aw_c >= (rand_mode ? aw_r : cfg_aw)) begin AWREADY = 1; s_awaddr = AWADDR; end
               else begin AWREADY = 0; aw_c++; end
            end else begin AWREADY = 0; aw_c = 0; aw_r = int'($urandom_range(0, 3)); end
            if (WVALID) begin
               if (w_c >= (rand_mode ? w_r : cfg_w)) begin WREADY = 1; s_wdata = WDATA; s_wstrb = WSTRB; end
               else begin WREADY = 0; w_c++; end
            end else begin WREADY = 0; w_c = 0; w_r = int'($urandom_range(0, 3)); end
            if (BREADY) begin
               if (b_c >= (rand_mode ? b_r : cfg_b)) begin
                  if (!BVALID)
                     for (int k = 0; k < 4; k++)
                        if (s_wstrb[k]) slv_mem[s_awaddr[5:2]][8*k +: 8] = s_wdata[8*k +: 8];
                  BVALID = 1; BRESP = rsp_for(s_awaddr);
               end else begin BVALID = 0; b_c++; end
            end else begin BVALID = 0; b_c = 0; b_r = int'($urandom_range(0, 3)); end
            if (ARVALID) begin
               if (ar_c >= (rand_mode ? ar_r : cfg_ar)) begin ARREADY = 1; s_araddr = ARADDR; end
               else begin ARREADY = 0; ar_c++; end
            end else begin ARREADY = 0; ar_c = 0; ar_r = int'($urandom_range(0, 3)); end
            if (RREADY) begin
               if (r_c >= (rand_mode ? r_r : cfg_r)) begin
                  RVALID = 1; RDATA = slv_mem[s_araddr[5:2]]; RRESP = rsp_for(s_araddr);
               end else begin RVALID = 0; r_c++; end
            end else begin RVALID = 0; r_c = 0; r_r = int'($urandom_range(0, 3)); end
         end
      end
   end

   // Write and read channel groups must never be active together.
   initial forever begin
      @(negedge ACLK);
      if ((AWVALID || WVALID || BREADY) && (ARVALID || RREADY)) overlap++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, cnt, exp_idx;
      logic [N-1:0] who, oh;
      logic [31:0]  e_data, v;
      logic [1:0]   e_resp;

      req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0; cfg_resp = 2'b00;
      rand_mode = 0;
      for (int k = 0; k < 16; k++) slv_mem[k] = 32'h1000_0000 | k;
      slv_mem[8] = 32'h1234_5678;
      slv_mem[9] = 32'hCAFE_F00D;

      // reset values
      ARESETN = 1'b0;
      repeat (3) @(negedge ACLK);
      check("rst_ctrl", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 64'd0);
      check("rst_addr", 64'({AWADDR, ARADDR}), 64'd0);
      check("rst_wdata", 64'({WDATA, WSTRB}), 64'd0);
      check("rst_rsp", 64'({rsp_valid, rsp_rdata, rsp_resp}), 64'd0);
      ARESETN = 1'b1;
      @(negedge ACLK);

      // zero-wait write from requester 0
      set_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      req = 2'b01;
      @(negedge ACLK);
      check("t1_c1_valid", 64'({AWVALID, WVALID, ARVALID}), 64'b110);
      check("t1_c1_awaddr", 64'(AWADDR), 64'h10);
      check("t1_c1_wdata", 64'({WDATA, WSTRB}), 64'hD_EADB_EEFF);
      req = 2'b00;
      @(negedge ACLK);
      check("t1_c2", 64'({AWVALID, WVALID, BREADY, rsp_valid}), 64'b00100);
      @(negedge ACLK);
      check("t1_c3_rsp", 64'(rsp_valid), 64'b01);
      check("t1_c3_data", 64'({rsp_rdata, rsp_resp}), 64'd0);
      @(negedge ACLK);
      check("t1_c4_rsp", 64'(rsp_valid), 64'd0);

      // read from requester 1 with slave waits; fields change mid-flight
      cfg_ar = 2; cfg_r = 3;
      set_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
      req = 2'b10;
      cyc = 0; cnt = 0;
      while (cyc < 20) begin
         @(negedge ACLK);
         cyc++;
         if (ARVALID) cnt++;
         if (cyc == 1) begin set_req(1, 1'b1, 32'h3C, 32'h5555_5555, 4'hF); req = 2'b00; end
         if (cyc == 3) check("t2_araddr", 64'(ARADDR), 64'h20);
         if (rsp_valid != '0) break;
      end
      check("t2_latency", 64'(cyc), 64'd8);
      check("t2_arvalid_cycles", 64'(cnt), 64'd3);
      check("t2_rsp", 64'(rsp_valid), 64'b10);
      check("t2_data", 64'({rsp_rdata, rsp_resp}), 64'h4_8D1_59E0);
      @(negedge ACLK);
      check("t2_pulse", 64'(rsp_valid), 64'd0);
      cfg_ar = 0; cfg_r = 0;

      // AW accepted at once, W accepted two cycles later
      cfg_w = 2;
      set_req(0, 1'b1, 32'h14, 32'h0BAD_F00D, 4'h3);
      req = 2'b01;
      @(negedge ACLK);
      check("t4_c1", 64'({AWVALID, WVALID}), 64'b11);
      req = 2'b00;
      @(negedge ACLK);
      check("t4_c2", 64'({AWVALID, WVALID, BREADY}), 64'b010);
      @(negedge ACLK);
      check("t4_c3", 64'({AWVALID, WVALID, BREADY}), 64'b010);
      @(negedge ACLK);
      check("t4_c4", 64'({AWVALID, WVALID, BREADY}), 64'b001);
      wait_rsp("t4", who);
      check("t4_rsp", 64'(who), 64'b01);
      @(negedge ACLK);
      cfg_w = 0;

      // read with SLVERR: response passed through with data
      cfg_ar = 1; cfg_resp = 2'b10;
      set_req(1, 1'b0, 32'h24, 32'h0, 4'h0);
      req = 2'b10;
      wait_rsp("t5", who);
      req = 2'b00;
      check("t5_rsp", 64'(who), 64'b10);
      check("t5_data", 64'(rsp_rdata), 64'hCAFE_F00D);
      check("t5_resp", 64'(rsp_resp), 64'b10);
      @(negedge ACLK);
      cfg_ar = 0;

      // write with DECERR from requester 1 while pointer sits at 0
      cfg_resp = 2'b11;
      set_req(1, 1'b1, 32'h28, 32'h55, 4'h1);
      req = 2'b10;
      wait_rsp("t5b", who);
      req = 2'b00;
      check("t5b_rsp", 64'(who), 64'b10);
      check("t5b_data", 64'({rsp_rdata, rsp_resp}), 64'b11);
      @(negedge ACLK);
      cfg_resp = 2'b00;

      // requester 0 write leaves the pointer at 1
      set_req(0, 1'b1, 32'h2C, 32'h77, 4'hF);
      req = 2'b01;
      wait_rsp("t6a", who);
      req = 2'b00;
      check("t6a_rsp", 64'(who), 64'b01);
      @(negedge ACLK);

      // reset during the read-data phase
      cfg_r = 30;
      set_req(0, 1'b0, 32'h20, 32'hFFFF_FFFF, 4'hF);
      req = 2'b01;
      cyc = 0;
      while (!RREADY && cyc < 20) begin
         @(negedge ACLK);
         cyc++;
      end
      check("t6_rready", 64'(RREADY), 64'd1);
      @(negedge ACLK);
      ARESETN = 1'b0;
      #1;
      check("t6_rst_ctrl", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 64'd0);
      check("t6_rst_addr", 64'({AWADDR, ARADDR}), 64'd0);
      check("t6_rst_wdata", 64'({WDATA, WSTRB}), 64'd0);
      check("t6_rst_rsp", 64'({rsp_valid, rsp_rdata, rsp_resp}), 64'd0);
      req = 2'b00;
      cfg_r = 0;
      repeat (3) @(negedge ACLK);
      ARESETN = 1'b1;
      cnt = 0;
      repeat (6) begin
         @(negedge ACLK);
         if (rsp_valid != '0) cnt++;
      end
      check("t6_no_lost_rsp", 64'(cnt), 64'd0);
      set_req(0, 1'b1, 32'h30, 32'h1111_1111, 4'hF);
      set_req(1, 1'b1, 32'h34, 32'h2222_2222, 4'hF);
      req = 2'b11;
      wait_rsp("t6_first", who);
      check("t6_first_grant", 64'(who), 64'b01);
      req = 2'b10;
      @(negedge ACLK);
      check("t6_pulse", 64'(rsp_valid), 64'd0);
      wait_rsp("t6_second", who);
      check("t6_second_grant", 64'(who), 64'b10);
      req = 2'b00;
      @(negedge ACLK);

      // randomized: all requesters held, random ops and slave waits
      rand_mode = 1;
      for (int k = 0; k < 16; k++) begin
         v = $urandom;
         slv_mem[k]   = v;
         model_mem[k] = v;
      end
      for (int i = 0; i < N; i++) new_op(i);
      exp_idx = 0;
      req = '1;
      for (int t = 0; t < 40; t++) begin
         wait_rsp("rnd", who);
         oh = '0;
         oh[exp_idx] = 1'b1;
         check("rnd_order", 64'(who), 64'(oh));
         if (op_we[exp_idx]) begin
            for (int k = 0; k < 4; k++)
               if (op_wstrb[exp_idx][k])
                  model_mem[op_addr[exp_idx][5:2]][8*k +: 8] = op_wdata[exp_idx][8*k +: 8];
            e_data = 32'd0;
         end else begin
            e_data = model_mem[op_addr[exp_idx][5:2]];
         end
         e_resp = op_addr[exp_idx][9:8];
         check("rnd_data", 64'({rsp_rdata, rsp_resp}), 64'({e_data, e_resp}));
         new_op(exp_idx);
         exp_idx = (exp_idx + 1) % N;
         @(negedge ACLK);
      end
      req = '0;
      repeat (5) @(negedge ACLK);
      check("rnd_quiet", 64'({AWVALID, WVALID, ARVALID, rsp_valid}), 64'd0);
      check("one_group_active", 64'(overlap), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
